// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sequential fixed-point square-root block.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_NEAREST = 1;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: consumes two radicand bits,
// produces one root bit and the updated partial remainder.
module sqrt_step #(
  parameter int RW = 10
) (
  input  logic [RW-1:0] rem_i,
  input  logic [RW-3:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [RW-1:0] rem_o,
  output logic [RW-3:0] root_o
);

  logic [RW-1:0] remShift;
  logic [RW-1:0] trial;

  // The trial subtrahend is 4*root+1; the partial remainder never exceeds
  // 2*root, so its top two bits are always clear before the shift.
  always_comb begin
    remShift = (rem_i << 2) | RW'(bits_i);
    trial    = {root_i, 2'b01};
    if (remShift >= trial) begin
      rem_o  = remShift - trial;
      root_o = (root_i << 1) | (RW-2)'(1);
    end else begin
      rem_o  = remShift;
      root_o = root_i << 1;
    end
  end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential unsigned fixed-point square root, one root bit per clock, with a
// valid/ready handshake on both sides and optional round-to-nearest.
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 8,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] root,
  output logic             exact
);

  localparam int N    = (WIDTH + FRAC) / 2;
  localparam int RW   = N + 2;
  localparam int RADW = 2 * N;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH + FRAC) % 2) != 0 || FRAC >= WIDTH || WIDTH < 4) begin : g_param_check
    $error("sqrt_seq: WIDTH+FRAC must be even, FRAC < WIDTH and WIDTH >= 4");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RADW-1:0]  rad_q, rad_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic             exact_q, exact_d;

  logic [RW-1:0]    stepRem;
  logic [N-1:0]     stepRoot;
  logic             roundUp;

  sqrt_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .root_i (acc_q),
    .bits_i (rad_q[RADW-1 -: 2]),
    .rem_o  (stepRem),
    .root_o (stepRoot)
  );

  // Final remainder above the truncated root means sqrt >= root + 0.5.
  assign roundUp = (ROUND == ROUND_NEAREST) && (stepRem > {2'b00, stepRoot});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    root_d  = root_q;
    exact_d = exact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rad_d   = RADW'(x) << FRAC;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = stepRem;
        acc_d = stepRoot;
        rad_d = rad_q << 2;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          root_d  = WIDTH'(stepRoot) + WIDTH'(roundUp);
          exact_d = (stepRem == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      root_q  <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      root_q  <= root_d;
      exact_q <= exact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign root      = root_q;
  assign exact     = exact_q;

endmodule
